midi_voice_allocator: RTL and testbench
=======================================

Name: midi_voice_allocator

Overview:
- Polyphonic successor to the single-voice MIDI processing path; accepts decoded MIDI messages and assigns them to NUM_VOICES voice slots.
- Supports note retrigger, lowest-free-slot allocation, oldest-voice stealing, sustain pedal (CC 64) and all-notes-off (CC 123).
- Sits between midi_reader and a bank of per-voice oscillators.
- Each voice slot exposes note, velocity, gate and a one-cycle trigger pulse.

Parameters:
- NUM_VOICES, 4, number of voice slots (2..16).
- AGE_WIDTH, 8, width of the per-voice saturating age counter.
- SUSTAIN_EN, 1, 1 = honour CC 64; 0 = ignore CC 64.

Ports:
- clk_in  input  1  system clock.
- rst_in  input  1  synchronous, active-high reset.
- status  input  4  message type nibble: 0x9 note-on, 0x8 note-off, 0xB control change.
- data_byte1  input  8  note number or controller number; bit 7 ignored.
- data_byte2  input  8  velocity or controller value; bit 7 ignored.
- valid_in  input  1  message valid.
- ready_out  output  1  allocator idle; message accepted when valid_in & ready_out.
- voice_note_out  output  7*NUM_VOICES  note per voice; voice i occupies bits [7i+6:7i].
- voice_vel_out  output  7*NUM_VOICES  velocity per voice, same packing.
- voice_on_out  output  NUM_VOICES  gate per voice.
- voice_trig_out  output  NUM_VOICES  one-cycle pulse on each voice (re)assignment.
- dropped_out  output  1  sticky: valid_in was seen while ready_out = 0.

Behaviour:
- Reset:
  - All voice outputs, held flags, ages, sustain state and dropped_out = 0.
  - ready_out = 1; FSM = IDLE.
  - Reset asserted mid-operation aborts any scan; the in-flight message is discarded.
- FSM IDLE:
  - ready_out = 1.
  - On valid_in, latch status/data (7-bit masked), deassert ready_out next cycle, go to SCAN with index 0.
- FSM SCAN: one voice per cycle, index 0..NUM_VOICES-1; records:
  - match: lowest-index voice with voice_on = 1 and note = latched note.
  - free: lowest-index voice with voice_on = 0.
  - oldest: voice with maximum age; ties resolved to the lowest index.
  - After the last index, go to COMMIT.
- FSM COMMIT (one cycle): applies the update, then returns to IDLE.
- Latency: accept at cycle 0; SCAN occupies cycles 1..NUM_VOICES; COMMIT at cycle NUM_VOICES+1; outputs and ready_out = 1 visible at cycle NUM_VOICES+2. Every message takes this path, including ignored ones.
- Note-on, velocity > 0:
  - Target = match if any, else free if any, else oldest.
  - Target gets note, velocity, voice_on = 1, held = 0, age = 0; voice_trig_out[target] = 1 for the cycle after COMMIT.
  - All other voices with voice_on = 1 increment age, saturating at 2^AGE_WIDTH-1.
- Note-on with velocity 0 is treated as note-off.
- Note-off:
  - If a matching voice exists and sustain is active: held = 1, gate stays 1.
  - If a matching voice exists and sustain is inactive: voice_on = 0; note and velocity retain their values.
  - If no voice matches: no change.
- CC 64, only when SUSTAIN_EN = 1:
  - data2 >= 64 sets sustain.
  - data2 < 64 clears sustain; every voice with held = 1 gets voice_on = 0 and held = 0.
- CC 123: all voice_on, held and age = 0; sustain state unchanged.
- Other status values and other controllers: no state change.
- valid_in while ready_out = 0: message ignored, dropped_out set; dropped_out is cleared only by reset.
- voice_trig_out is 0 at all times except the single pulse cycle.

Test Plan:
- Reset, then note-on 60/100 with NUM_VOICES = 4 -> at cycle 6, voice 0 = note 60, vel 100, on = 1; trig[0] pulses for 1 cycle; ready_out returns to 1.
- Note-ons 60, 62, 64, 65, then 67 -> 67 steals voice 0 (oldest, age 3); trig[0] pulses; voices 1-3 unchanged.
- Note-on 60/100, then note-on 60/50 -> voice 0 retriggered with vel 50; voice 1 stays off.
- CC64 = 127, note-on 60, note-off 60 -> voice 0 still on; CC64 = 0 -> voice 0 off.
- Note-on 60, then note-on 60 with velocity 0 -> voice 0 off, note stays 60; CC123 with two voices on -> all gates 0.
- Pulse valid_in during SCAN -> message ignored, dropped_out = 1 until reset; assert rst_in mid-SCAN -> all outputs 0, ready_out = 1.

Source files
------------

// File: rtl/midi_voice_allocator.sv
// midi_voice_allocator
//   Polyphonic voice allocator between midi_reader and a bank of per-voice
//   oscillators. Each accepted MIDI message is scanned against all voice slots
//   (one slot per cycle) and then committed in a single cycle, so every message
//   takes NUM_VOICES+2 cycles from acceptance until ready_out returns.
//
// Ports
//   clk_in          system clock
//   rst_in          synchronous, active-high reset
//   status          message type nibble (0x9 note-on, 0x8 note-off, 0xB CC)
//   data_byte1      note / controller number (bit 7 ignored)
//   data_byte2      velocity / controller value (bit 7 ignored)
//   valid_in        message valid; accepted when valid_in & ready_out
//   ready_out       allocator idle
//   voice_note_out  7 bits per voice, voice i at [7i+6:7i]
//   voice_vel_out   7 bits per voice, same packing
//   voice_on_out    gate per voice
//   voice_trig_out  one-cycle pulse on each voice (re)assignment
//   dropped_out     sticky: valid_in seen while busy (cleared by reset only)

module midi_voice_allocator #(
  parameter int unsigned NUM_VOICES = 4,
  parameter int unsigned AGE_WIDTH  = 8,
  parameter bit          SUSTAIN_EN = 1'b1
) (
  input  logic                      clk_in,
  input  logic                      rst_in,
  input  logic [3:0]                status,
  input  logic [7:0]                data_byte1,
  input  logic [7:0]                data_byte2,
  input  logic                      valid_in,
  output logic                      ready_out,
  output logic [7*NUM_VOICES-1:0]   voice_note_out,
  output logic [7*NUM_VOICES-1:0]   voice_vel_out,
  output logic [NUM_VOICES-1:0]     voice_on_out,
  output logic [NUM_VOICES-1:0]     voice_trig_out,
  output logic                      dropped_out
);

  localparam int unsigned IDX_W = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;

  typedef logic [IDX_W-1:0]     idx_t;
  typedef logic [AGE_WIDTH-1:0] age_t;

  localparam idx_t LAST_IDX = idx_t'(NUM_VOICES - 1);
  localparam age_t AGE_MAX  = '1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SCAN,
    S_COMMIT
  } state_t;

  state_t                  state_q, state_d;
  idx_t                    idx_q, idx_d;

  // Latched message
  logic [3:0]              stat_q, stat_d;
  logic [6:0]              d1_q, d1_d;
  logic [6:0]              d2_q, d2_d;

  // Scan results
  logic                    match_q, match_d;
  idx_t                    match_idx_q, match_idx_d;
  logic                    free_q, free_d;
  idx_t                    free_idx_q, free_idx_d;
  idx_t                    old_idx_q, old_idx_d;
  age_t                    old_age_q, old_age_d;

  // Voice state
  logic [6:0]              note_q [NUM_VOICES];
  logic [6:0]              note_d [NUM_VOICES];
  logic [6:0]              vel_q  [NUM_VOICES];
  logic [6:0]              vel_d  [NUM_VOICES];
  age_t                    age_q  [NUM_VOICES];
  age_t                    age_d  [NUM_VOICES];
  logic [NUM_VOICES-1:0]   on_q, on_d;
  logic [NUM_VOICES-1:0]   held_q, held_d;
  logic [NUM_VOICES-1:0]   trig_q, trig_d;
  logic                    sustain_q, sustain_d;
  logic                    dropped_q, dropped_d;

  logic                    is_note_on;
  logic                    is_note_off;
  idx_t                    target;

  // Bit 7 of both data bytes is architecturally ignored.
  logic unused_data_msb;
  assign unused_data_msb = data_byte1[7] ^ data_byte2[7];

  assign ready_out   = (state_q == S_IDLE);
  assign is_note_on  = (stat_q == 4'h9) && (d2_q != 7'd0);
  assign is_note_off = (stat_q == 4'h8) || ((stat_q == 4'h9) && (d2_q == 7'd0));

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    stat_d      = stat_q;
    d1_d        = d1_q;
    d2_d        = d2_q;
    match_d     = match_q;
    match_idx_d = match_idx_q;
    free_d      = free_q;
    free_idx_d  = free_idx_q;
    old_idx_d   = old_idx_q;
    old_age_d   = old_age_q;
    note_d      = note_q;
    vel_d       = vel_q;
    age_d       = age_q;
    on_d        = on_q;
    held_d      = held_q;
    trig_d      = '0;
    sustain_d   = sustain_q;
    dropped_d   = dropped_q | (valid_in & ~ready_out);

    // Retrigger beats free slot, free slot beats stealing the oldest voice.
    if (match_q)     target = match_idx_q;
    else if (free_q) target = free_idx_q;
    else             target = old_idx_q;

    case (state_q)
      S_IDLE: begin
        if (valid_in) begin
          stat_d  = status;
          d1_d    = data_byte1[6:0];
          d2_d    = data_byte2[6:0];
          match_d = 1'b0;
          free_d  = 1'b0;
          idx_d   = '0;
          state_d = S_SCAN;
        end
      end

      S_SCAN: begin
        if (!match_q && on_q[idx_q] && (note_q[idx_q] == d1_q)) begin
          match_d     = 1'b1;
          match_idx_d = idx_q;
        end
        if (!free_q && !on_q[idx_q]) begin
          free_d     = 1'b1;
          free_idx_d = idx_q;
        end
        // Strict compare keeps the lowest index on equal ages.
        if ((idx_q == '0) || (age_q[idx_q] > old_age_q)) begin
          old_idx_d = idx_q;
          old_age_d = age_q[idx_q];
        end
        if (idx_q == LAST_IDX) state_d = S_COMMIT;
        else                   idx_d   = idx_q + idx_t'(1);
      end

      S_COMMIT: begin
        state_d = S_IDLE;
        if (is_note_on) begin
          for (int unsigned i = 0; i < NUM_VOICES; i++) begin
            if (idx_t'(i) == target) begin
              note_d[i] = d1_q;
              vel_d[i]  = d2_q;
              on_d[i]   = 1'b1;
              held_d[i] = 1'b0;
              age_d[i]  = '0;
              trig_d[i] = 1'b1;
            end else if (on_q[i] && (age_q[i] != AGE_MAX)) begin
              age_d[i] = age_q[i] + age_t'(1);
            end
          end
        end else if (is_note_off) begin
          if (match_q) begin
            if (sustain_q) held_d[match_idx_q] = 1'b1;
            else           on_d[match_idx_q]   = 1'b0;
          end
        end else if (stat_q == 4'hB) begin
          if (SUSTAIN_EN && (d1_q == 7'd64)) begin
            if (d2_q >= 7'd64) begin
              sustain_d = 1'b1;
            end else begin
              sustain_d = 1'b0;
              on_d      = on_q & ~held_q;
              held_d    = '0;
            end
          end else if (d1_q == 7'd123) begin
            on_d   = '0;
            held_d = '0;
            for (int unsigned i = 0; i < NUM_VOICES; i++) age_d[i] = '0;
          end
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q     <= S_IDLE;
      idx_q       <= '0;
      stat_q      <= '0;
      d1_q        <= '0;
      d2_q        <= '0;
      match_q     <= 1'b0;
      match_idx_q <= '0;
      free_q      <= 1'b0;
      free_idx_q  <= '0;
      old_idx_q   <= '0;
      old_age_q   <= '0;
      note_q      <= '{default: '0};
      vel_q       <= '{default: '0};
      age_q       <= '{default: '0};
      on_q        <= '0;
      held_q      <= '0;
      trig_q      <= '0;
      sustain_q   <= 1'b0;
      dropped_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      stat_q      <= stat_d;
      d1_q        <= d1_d;
      d2_q        <= d2_d;
      match_q     <= match_d;
      match_idx_q <= match_idx_d;
      free_q      <= free_d;
      free_idx_q  <= free_idx_d;
      old_idx_q   <= old_idx_d;
      old_age_q   <= old_age_d;
      note_q      <= note_d;
      vel_q       <= vel_d;
      age_q       <= age_d;
      on_q        <= on_d;
      held_q      <= held_d;
      trig_q      <= trig_d;
      sustain_q   <= sustain_d;
      dropped_q   <= dropped_d;
    end
  end

  always_comb begin
    voice_note_out = '0;
    voice_vel_out  = '0;
    for (int unsigned i = 0; i < NUM_VOICES; i++) begin
      voice_note_out[7*i +: 7] = note_q[i];
      voice_vel_out[7*i +: 7]  = vel_q[i];
    end
  end

  assign voice_on_out   = on_q;
  assign voice_trig_out = trig_q;
  assign dropped_out    = dropped_q;

endmodule

// File: tb/tb_midi_voice_allocator.sv
// tb_midi_voice_allocator
//   Drives directed and random MIDI messages into midi_voice_allocator and
//   compares every output, every cycle, against a behavioural model of the
//   allocation rules. A few literal expectations pin the model itself.

module tb_midi_voice_allocator;

  localparam int NV   = 4;
  localparam int AW   = 3;
  localparam int AMAX = (1 << AW) - 1;

  logic              clk_in = 1'b0;
  logic              rst_in;
  logic [3:0]        status;
  logic [7:0]        data_byte1;
  logic [7:0]        data_byte2;
  logic              valid_in;
  logic              ready_out;
  logic [7*NV-1:0]   voice_note_out;
  logic [7*NV-1:0]   voice_vel_out;
  logic [NV-1:0]     voice_on_out;
  logic [NV-1:0]     voice_trig_out;
  logic              dropped_out;

  always #5 clk_in = ~clk_in;

  midi_voice_allocator #(
    .NUM_VOICES(NV),
    .AGE_WIDTH (AW),
    .SUSTAIN_EN(1'b1)
  ) dut (
    .clk_in        (clk_in),
    .rst_in        (rst_in),
    .status        (status),
    .data_byte1    (data_byte1),
    .data_byte2    (data_byte2),
    .valid_in      (valid_in),
    .ready_out     (ready_out),
    .voice_note_out(voice_note_out),
    .voice_vel_out (voice_vel_out),
    .voice_on_out  (voice_on_out),
    .voice_trig_out(voice_trig_out),
    .dropped_out   (dropped_out)
  );

  // Behavioural model: what the outputs must show right now.
  int m_note [NV];
  int m_vel  [NV];
  int m_age  [NV];
  bit m_on   [NV];
  bit m_held [NV];
  bit m_trig [NV];
  bit m_sus;
  bit m_ready;
  bit m_dropped;

  int vectors     = 0;
  int miscompares = 0;
  bit check_en    = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      if (miscompares <= 40)
        $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7*NV-1:0] exp_notes();
    logic [7*NV-1:0] r;
    for (int i = 0; i < NV; i++) r[7*i +: 7] = 7'(m_note[i]);
    return r;
  endfunction

  function automatic logic [7*NV-1:0] exp_vels();
    logic [7*NV-1:0] r;
    for (int i = 0; i < NV; i++) r[7*i +: 7] = 7'(m_vel[i]);
    return r;
  endfunction

  function automatic logic [NV-1:0] exp_on();
    logic [NV-1:0] r;
    for (int i = 0; i < NV; i++) r[i] = m_on[i];
    return r;
  endfunction

  function automatic logic [NV-1:0] exp_trig();
    logic [NV-1:0] r;
    for (int i = 0; i < NV; i++) r[i] = m_trig[i];
    return r;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NV; i++) begin
      m_note[i] = 0; m_vel[i] = 0; m_age[i] = 0;
      m_on[i] = 1'b0; m_held[i] = 1'b0; m_trig[i] = 1'b0;
    end
    m_sus     = 1'b0;
    m_ready   = 1'b1;
    m_dropped = 1'b0;
  endtask

  task automatic clear_trig();
    for (int i = 0; i < NV; i++) m_trig[i] = 1'b0;
  endtask

  task automatic model_commit(input logic [3:0] st, input logic [7:0] b1, input logic [7:0] b2);
    int n, v, match, tgt;
    n = int'(b1[6:0]);
    v = int'(b2[6:0]);
    match = -1;
    for (int i = 0; i < NV; i++)
      if (match < 0 && m_on[i] && m_note[i] == n) match = i;
    if (st == 4'h9 && v != 0) begin
      tgt = match;
      for (int i = 0; i < NV; i++)
        if (tgt < 0 && !m_on[i]) tgt = i;
      if (tgt < 0) begin
        tgt = 0;
        for (int i = 1; i < NV; i++)
          if (m_age[i] > m_age[tgt]) tgt = i;
      end
      for (int i = 0; i < NV; i++)
        if (i != tgt && m_on[i] && m_age[i] < AMAX) m_age[i]++;
      m_note[tgt] = n;
      m_vel[tgt]  = v;
      m_on[tgt]   = 1'b1;
      m_held[tgt] = 1'b0;
      m_age[tgt]  = 0;
      m_trig[tgt] = 1'b1;
    end else if (st == 4'h8 || st == 4'h9) begin
      if (match >= 0) begin
        if (m_sus) m_held[match] = 1'b1;
        else       m_on[match]   = 1'b0;
      end
    end else if (st == 4'hB) begin
      if (n == 64) begin
        if (v >= 64) m_sus = 1'b1;
        else begin
          m_sus = 1'b0;
          for (int i = 0; i < NV; i++)
            if (m_held[i]) begin m_on[i] = 1'b0; m_held[i] = 1'b0; end
        end
      end else if (n == 123) begin
        for (int i = 0; i < NV; i++) begin
          m_on[i] = 1'b0; m_held[i] = 1'b0; m_age[i] = 0;
        end
      end
    end
  endtask

  always @(negedge clk_in) begin
    if (check_en) begin
      chk("ready",   64'(ready_out),      64'(m_ready));
      chk("note",    64'(voice_note_out), 64'(exp_notes()));
      chk("vel",     64'(voice_vel_out),  64'(exp_vels()));
      chk("gate",    64'(voice_on_out),   64'(exp_on()));
      chk("trig",    64'(voice_trig_out), 64'(exp_trig()));
      chk("dropped", 64'(dropped_out),    64'(m_dropped));
    end
  end

  // Returns #1 after the commit edge, while any trigger pulse is visible.
  // poke: scan/commit cycle (1..NV+1) at which a stray valid_in is pulsed.
  // rstk: scan cycle (1..NV) at which reset aborts the message. 0 = none.
  task automatic send(input logic [3:0] st, input logic [7:0] b1, input logic [7:0] b2,
                      input int poke, input int rstk);
    @(negedge clk_in);
    status = st; data_byte1 = b1; data_byte2 = b2; valid_in = 1'b1;
    @(posedge clk_in);
    #1;
    valid_in = 1'b0;
    m_ready  = 1'b0;
    clear_trig();
    for (int k = 1; k <= NV + 1; k++) begin
      if (k == rstk) begin
        @(negedge clk_in);
        rst_in = 1'b1;
        @(posedge clk_in);
        #1;
        rst_in = 1'b0;
        model_reset();
        return;
      end
      if (k == poke) begin
        @(negedge clk_in);
        status = 4'($urandom); data_byte1 = 8'($urandom); data_byte2 = 8'($urandom);
        valid_in = 1'b1;
        @(posedge clk_in);
        #1;
        valid_in  = 1'b0;
        m_dropped = 1'b1;
      end else begin
        @(posedge clk_in);
      end
    end
    #1;
    m_ready = 1'b1;
    model_commit(st, b1, b2);
  endtask

  task automatic msg(input logic [3:0] st, input int b1, input int b2);
    send(st, 8'(b1), 8'(b2), 0, 0);
  endtask

  task automatic do_reset();
    @(negedge clk_in);
    rst_in = 1'b1;
    @(posedge clk_in);
    #1;
    rst_in = 1'b0;
    model_reset();
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk_in);
      #1;
      clear_trig();
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] st;
    logic [7:0] b1, b2;
    int r, poke, rstk;

    rst_in = 1'b1; valid_in = 1'b0; status = '0; data_byte1 = '0; data_byte2 = '0;
    repeat (3) @(posedge clk_in);
    #1;
    rst_in = 1'b0;
    model_reset();
    check_en = 1'b1;

    chk("rst_ready",   64'(ready_out), 64'd1);
    chk("rst_gate",    64'(voice_on_out), 64'd0);
    chk("rst_note",    64'(voice_note_out), 64'd0);
    chk("rst_dropped", 64'(dropped_out), 64'd0);

    // First note lands on voice 0, trigger lasts exactly one cycle.
    msg(4'h9, 60, 100);
    chk("A_note0",  64'(voice_note_out[6:0]), 64'd60);
    chk("A_vel0",   64'(voice_vel_out[6:0]), 64'd100);
    chk("A_gate",   64'(voice_on_out), 64'b0001);
    chk("A_trig",   64'(voice_trig_out), 64'b0001);
    chk("A_ready",  64'(ready_out), 64'd1);
    idle(1);
    chk("A_trig_gone", 64'(voice_trig_out), 64'd0);

    // Fifth note steals the oldest voice.
    do_reset();
    msg(4'h9, 60, 100); msg(4'h9, 62, 100); msg(4'h9, 64, 100); msg(4'h9, 65, 100);
    msg(4'h9, 67, 90);
    chk("B_notes", 64'(voice_note_out), 64'({7'd65, 7'd64, 7'd62, 7'd67}));
    chk("B_trig",  64'(voice_trig_out), 64'b0001);

    // Retrigger of a sounding note.
    do_reset();
    msg(4'h9, 60, 100); msg(4'h9, 60, 50);
    chk("C_vel0", 64'(voice_vel_out[6:0]), 64'd50);
    chk("C_gate", 64'(voice_on_out), 64'b0001);

    // Sustain pedal holds then releases.
    do_reset();
    msg(4'hB, 64, 127); msg(4'h9, 60, 100); msg(4'h8, 60, 64);
    chk("D_held", 64'(voice_on_out), 64'b0001);
    msg(4'hB, 64, 0);
    chk("D_release", 64'(voice_on_out), 64'b0000);

    // Velocity-0 note-on and all-notes-off.
    do_reset();
    msg(4'h9, 60, 100); msg(4'h9, 60, 0);
    chk("E_off",   64'(voice_on_out), 64'd0);
    chk("E_note0", 64'(voice_note_out[6:0]), 64'd60);
    msg(4'h9, 60, 100); msg(4'h9, 62, 100);
    chk("E_two_on", 64'(voice_on_out), 64'b0011);
    msg(4'hB, 123, 0);
    chk("E_allOff", 64'(voice_on_out), 64'd0);

    // Drop detection and mid-scan reset.
    do_reset();
    send(4'h9, 8'd60, 8'd100, 2, 0);
    chk("F_dropped", 64'(dropped_out), 64'd1);
    chk("F_note0",   64'(voice_note_out[6:0]), 64'd60);
    msg(4'h9, 62, 100);
    chk("F_sticky",  64'(dropped_out), 64'd1);
    send(4'h9, 8'd64, 8'd100, 0, 2);
    chk("F_rst_gate",  64'(voice_on_out), 64'd0);
    chk("F_rst_note",  64'(voice_note_out), 64'd0);
    chk("F_rst_ready", 64'(ready_out), 64'd1);
    chk("F_rst_drop",  64'(dropped_out), 64'd0);

    // Age saturation and tie-break: voices 0 and 1 both reach the max age,
    // so the steal must pick voice 0.
    do_reset();
    msg(4'h9, 60, 100); msg(4'h9, 61, 100);
    repeat (7) begin msg(4'h9, 70, 100); msg(4'h8, 70, 0); end
    msg(4'h9, 71, 100); msg(4'h9, 72, 100); msg(4'h9, 73, 100);
    chk("G_steal", 64'(voice_note_out[6:0]), 64'd73);
    chk("G_keep1", 64'(voice_note_out[13:7]), 64'd61);

    // Random traffic.
    do_reset();
    for (int n = 0; n < 400; n++) begin
      r = int'($urandom_range(0, 99));
      if (r < 40)      st = 4'h9;
      else if (r < 60) st = 4'h8;
      else if (r < 80) st = 4'hB;
      else             st = 4'($urandom);
      if (st == 4'hB) begin
        r = int'($urandom_range(0, 99));
        if (r < 45)      b1 = 8'd64;
        else if (r < 52) b1 = 8'd123;
        else             b1 = 8'($urandom);
        b2 = 8'($urandom);
      end else begin
        b1 = 8'(60 + $urandom_range(0, 7));
        if ($urandom_range(0, 1) == 1) b1[7] = 1'b1;
        b2 = ($urandom_range(0, 4) == 0) ? 8'h00 : 8'($urandom_range(1, 255));
      end
      poke = ($urandom_range(0, 14) == 0) ? int'($urandom_range(1, NV + 1)) : 0;
      rstk = ($urandom_range(0, 59) == 0) ? int'($urandom_range(1, NV)) : 0;
      send(st, b1, b2, poke, rstk);
      if ($urandom_range(0, 3) == 0) idle(int'($urandom_range(1, 3)));
    end

    idle(3);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
